// File: rtl/regwrite_port_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter: FSM encoding,
// the hard-wired zero register and default port widths.
package regwrite_port_arbiter_pkg;

    localparam int DEFAULT_AW = 5;
    localparam int DEFAULT_DW = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Encoding of last_owner: 1 means A was the last requester accepted.
    localparam logic OWNER_A = 1'b1;
    localparam logic OWNER_B = 1'b0;

endpackage

// File: rtl/regwrite_port_arbiter_mux2.sv
// Plain 2:1 mux used for both the destination-address and write-data paths.
// s_i=1 selects a_i, s_i=0 selects b_i.
module regwrite_port_arbiter_mux2
    import regwrite_port_arbiter_pkg::*;
#(
    parameter int W = DEFAULT_AW
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         s_i,
    output logic [W-1:0] y_o
);

    assign y_o = s_i ? a_i : b_i;

endmodule

// File: rtl/regwrite_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port between A and B,
// with a bounded hold count so a continuously requesting owner cannot starve the other.
module regwrite_port_arbiter
    import regwrite_port_arbiter_pkg::*;
#(
    parameter int AW       = DEFAULT_AW,
    parameter int DW       = DEFAULT_DW,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] data_a,
    output logic          ack_a,
    input  logic          req_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] data_b,
    output logic          ack_b,
    output logic          sel,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy
);

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    hold_cnt_q, hold_cnt_d;
    logic          last_owner_q;
    logic          sel_q;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;

    logic          grant_a, grant_b;
    logic          accept;
    logic [AW-1:0] mux_addr;
    logic [DW-1:0] mux_data;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_a && (!req_b || last_owner_q == OWNER_B)) begin
                    grant_a    = 1'b1;
                    state_d    = ST_OWN_A;
                    hold_cnt_d = 4'd0;
                end else if (req_b) begin
                    grant_b    = 1'b1;
                    state_d    = ST_OWN_B;
                    hold_cnt_d = 4'd0;
                end
            end
            ST_OWN_A: begin
                if (req_a && (!req_b || hold_cnt_q < HOLD_LIM)) begin
                    grant_a    = 1'b1;
                    hold_cnt_d = (hold_cnt_q >= HOLD_LIM) ? hold_cnt_q : hold_cnt_q + 4'd1;
                end else if (req_b) begin
                    grant_b    = 1'b1;
                    state_d    = ST_OWN_B;
                    hold_cnt_d = 4'd0;
                end else begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = 4'd0;
                end
            end
            ST_OWN_B: begin
                if (req_b && (!req_a || hold_cnt_q < HOLD_LIM)) begin
                    grant_b    = 1'b1;
                    hold_cnt_d = (hold_cnt_q >= HOLD_LIM) ? hold_cnt_q : hold_cnt_q + 4'd1;
                end else if (req_a) begin
                    grant_a    = 1'b1;
                    state_d    = ST_OWN_A;
                    hold_cnt_d = 4'd0;
                end else begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = 4'd0;
            end
        endcase
    end

    // Acks are suppressed during reset so nothing accepted in that cycle is lost silently.
    assign ack_a  = grant_a & ~rst;
    assign ack_b  = grant_b & ~rst;
    assign accept = ack_a | ack_b;

    // When idle the select parks on its last value so the muxes do not toggle.
    assign sel = ack_a ? 1'b1 : (ack_b ? 1'b0 : sel_q);

    regwrite_port_arbiter_mux2 #(.W(AW)) u_addr_mux (
        .a_i (addr_a),
        .b_i (addr_b),
        .s_i (sel),
        .y_o (mux_addr)
    );

    regwrite_port_arbiter_mux2 #(.W(DW)) u_data_mux (
        .a_i (data_a),
        .b_i (data_b),
        .s_i (sel),
        .y_o (mux_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= 4'd0;
            last_owner_q <= OWNER_B;
            sel_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            wr_en_q    <= 1'b0;
            if (accept) begin
                last_owner_q <= ack_a ? OWNER_A : OWNER_B;
                sel_q        <= sel;
                // Writes to the hard-wired zero register are acked but dropped.
                if (mux_addr != AW'(REG_ZERO)) begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= mux_addr;
                    wr_data_q <= mux_data;
                end
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_regwrite_port_arbiter.sv
// Directed bench for the write-port arbiter: reset, single grants, round-robin
// rotation, zero-register drop, hold saturation and mid-stream reset.
module tb_regwrite_port_arbiter;

    logic        clk;
    logic        rst;
    logic        req_a, req_b;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic        ack_a, ack_b, sel, wr_en, busy;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int checks;
    int failures;

    regwrite_port_arbiter #(.AW(5), .DW(32), .MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req_a),
        .addr_a  (addr_a),
        .data_a  (data_a),
        .ack_a   (ack_a),
        .req_b   (req_b),
        .addr_b  (addr_b),
        .data_b  (data_b),
        .ack_b   (ack_b),
        .sel     (sel),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick;
        $display("txn t=%0t rst=%b req_a=%b ack_a=%b req_b=%b ack_b=%b sel=%b wr_en=%b wr_addr=%0d wr_data=%h busy=%b",
                 $time, rst, req_a, ack_a, req_b, ack_b, sel, wr_en, wr_addr, wr_data, busy);
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        logic exp_a;
        checks   = 0;
        failures = 0;
        rst    = 1'b1;
        req_a  = 1'b0; addr_a = 5'd0; data_a = 32'h0;
        req_b  = 1'b0; addr_b = 5'd0; data_b = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("reset_wr_en",   32'(wr_en),   32'd0);
        check("reset_wr_addr", 32'(wr_addr), 32'd0);
        check("reset_wr_data", wr_data,      32'd0);
        check("reset_busy",    32'(busy),    32'd0);
        check("reset_acks",    32'({ack_a, ack_b}), 32'd0);

        // Single A request from IDLE.
        req_a = 1'b1; addr_a = 5'd3; data_a = 32'hDEAD0001;
        settle();
        check("single_a_ack_a", 32'(ack_a), 32'd1);
        check("single_a_ack_b", 32'(ack_b), 32'd0);
        check("single_a_sel",   32'(sel),   32'd1);
        tick();
        req_a = 1'b0;
        settle();
        check("single_a_wr_en",   32'(wr_en),   32'd1);
        check("single_a_wr_addr", 32'(wr_addr), 32'd3);
        check("single_a_wr_data", wr_data,      32'hDEAD0001);
        check("single_a_busy",    32'(busy),    32'd1);
        check("idle_no_ack",      32'({ack_a, ack_b}), 32'd0);
        check("idle_sel_holds",   32'(sel),     32'd1);
        tick();
        check("idle_wr_en",   32'(wr_en),   32'd0);
        check("idle_wr_addr", 32'(wr_addr), 32'd3);
        check("idle_busy",    32'(busy),    32'd0);

        // last_owner is A now, so a tie from IDLE goes to B.
        req_a = 1'b1; addr_a = 5'd1; data_a = 32'h11;
        req_b = 1'b1; addr_b = 5'd2; data_b = 32'h22;
        settle();
        check("tie_after_a_ack_b", 32'(ack_b), 32'd1);
        check("tie_after_a_ack_a", 32'(ack_a), 32'd0);
        check("tie_after_a_sel",   32'(sel),   32'd0);
        tick();
        req_a = 1'b0; req_b = 1'b0;
        settle();
        check("tie_after_a_wr_addr", 32'(wr_addr), 32'd2);
        check("tie_after_a_wr_data", wr_data,      32'h22);
        tick();

        // Continuous contention: last_owner=B, expect A,A,A,A,B,B,B,B,A.
        req_a = 1'b1; addr_a = 5'd7;
        req_b = 1'b1; addr_b = 5'd9;
        for (int i = 0; i < 9; i++) begin
            data_a = 32'hA000_0000 + 32'(i);
            data_b = 32'hB000_0000 + 32'(i);
            exp_a  = (i < 4) || (i == 8);
            settle();
            check($sformatf("rr_ack_a_%0d", i), 32'(ack_a), 32'(exp_a));
            check($sformatf("rr_ack_b_%0d", i), 32'(ack_b), 32'(!exp_a));
            tick();
            check($sformatf("rr_wr_en_%0d", i),   32'(wr_en),   32'd1);
            check($sformatf("rr_wr_addr_%0d", i), 32'(wr_addr), exp_a ? 32'd7 : 32'd9);
            check($sformatf("rr_wr_data_%0d", i), wr_data,
                  exp_a ? 32'hA000_0000 + 32'(i) : 32'hB000_0000 + 32'(i));
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
        check("rr_drain_wr_en", 32'(wr_en), 32'd0);
        check("rr_drain_busy",  32'(busy),  32'd0);

        // Write to register zero: acked, but no write and the port holds.
        req_b = 1'b1; addr_b = 5'd0; data_b = 32'h12345678;
        settle();
        check("zero_ack_b", 32'(ack_b), 32'd1);
        tick();
        req_b = 1'b0;
        settle();
        check("zero_wr_en",   32'(wr_en),   32'd0);
        check("zero_wr_addr", 32'(wr_addr), 32'd7);
        check("zero_wr_data", wr_data,      32'hA000_0008);
        check("zero_busy",    32'(busy),    32'd1);
        tick();

        // A alone for 10 cycles, then B arrives with the hold count saturated.
        req_a = 1'b1; addr_a = 5'd4; data_a = 32'h44;
        for (int i = 0; i < 10; i++) begin
            settle();
            check($sformatf("alone_ack_a_%0d", i), 32'(ack_a), 32'd1);
            tick();
        end
        req_b = 1'b1; addr_b = 5'd6; data_b = 32'h66;
        settle();
        check("sat_ack_b", 32'(ack_b), 32'd1);
        check("sat_ack_a", 32'(ack_a), 32'd0);
        check("sat_sel",   32'(sel),   32'd0);
        tick();
        req_b = 1'b0;
        settle();
        check("sat_wr_addr", 32'(wr_addr), 32'd6);
        check("sat_wr_data", wr_data,      32'h66);
        check("back_to_a_ack_a", 32'(ack_a), 32'd1);

        // Reset in the same cycle A would be accepted.
        rst = 1'b1;
        settle();
        check("rst_ack_a", 32'(ack_a), 32'd0);
        check("rst_ack_b", 32'(ack_b), 32'd0);
        tick();
        rst = 1'b0; req_a = 1'b0;
        settle();
        check("rst_wr_en",   32'(wr_en),   32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data,      32'd0);
        check("rst_busy",    32'(busy),    32'd0);

        // After reset a tie goes to A, then B.
        req_a = 1'b1; addr_a = 5'd10; data_a = 32'hAAAA;
        req_b = 1'b1; addr_b = 5'd11; data_b = 32'hBBBB;
        settle();
        check("post_rst_tie_ack_a", 32'(ack_a), 32'd1);
        check("post_rst_tie_ack_b", 32'(ack_b), 32'd0);
        tick();
        req_a = 1'b0;
        settle();
        check("post_rst_wr_addr_a", 32'(wr_addr), 32'd10);
        check("post_rst_ack_b",     32'(ack_b),   32'd1);
        tick();
        req_b = 1'b0;
        settle();
        check("post_rst_wr_addr_b", 32'(wr_addr), 32'd11);
        check("post_rst_wr_data_b", wr_data,      32'hBBBB);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
